// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command feeder.
// Command codes, FSM states, image geometry.
package lcd_pkg;

  localparam int LCD_W  = 12;
  localparam int LCD_H  = 9;
  localparam int PIXELS = LCD_W * LCD_H;

  localparam logic [2:0] CMD_LOAD     = 3'd0;
  localparam logic [2:0] CMD_ZOOM_IN  = 3'd1;
  localparam logic [2:0] CMD_ZOOM_FIT = 3'd2;
  localparam logic [2:0] CMD_SHIFT_R  = 3'd3;
  localparam logic [2:0] CMD_SHIFT_L  = 3'd4;
  localparam logic [2:0] CMD_SHIFT_U  = 3'd5;
  localparam logic [2:0] CMD_SHIFT_D  = 3'd6;
  localparam logic [2:0] CMD_RSVD     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_LOAD,
    ST_WAIT
  } fsm_e;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] c,
    input logic       en
  );
    return (en && c != 8'hFF) ? c + 8'd1 : c;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous command FIFO.
// Pointer MSB distinguishes full from empty.
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign empty   = (wp == rp);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp[AW-1:0]];

  // pointer update; push and pop may coincide
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lcd_cmd_feeder.sv
// Queues host commands and feeds the LCD controller.
// Streams the pixel ROM during a load, reports completion.
module lcd_cmd_feeder
  import lcd_pkg::*;
#(
  parameter int WIDTH  = LCD_W,
  parameter int HEIGHT = LCD_H,
  parameter int ADDR_W = 7,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        host_cmd,
  input  logic              host_valid,
  output logic              host_ready,
  output logic              img_rd,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [7:0]        img_data,
  output logic [2:0]        ctrl_cmd,
  output logic              ctrl_cmd_valid,
  output logic [7:0]        ctrl_datain,
  input  logic              ctrl_busy,
  input  logic              ctrl_output_valid,
  output logic              done,
  output logic [7:0]        done_count,
  output logic              err
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NPIX - 1);

  fsm_e              state;
  fsm_e              state_nx;
  logic [2:0]        head;
  logic [2:0]        cmd_q;
  logic              loaded;
  logic [ADDR_W-1:0] k;
  logic [7:0]        cnt;
  logic [7:0]        done_cnt_q;
  logic              done_q;
  logic              err_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              drop;

  lcd_cmd_fifo #(
    .DEPTH (QDEPTH),
    .W     (3)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (host_valid),
    .din   (host_cmd),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign host_ready = reset && !fifo_full;
  assign done       = reset && done_q;
  assign err        = reset && err_q;
  assign done_count = reset ? done_cnt_q : 8'd0;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // next state, pop and drop decision
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    drop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty && !ctrl_busy) begin
          pop = 1'b1;
          if (head == CMD_LOAD || loaded)
            state_nx = ST_ISSUE;
          else
            drop = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_nx = (cmd_q == CMD_LOAD) ?
                   ST_LOAD : ST_WAIT;
      end
      ST_LOAD: begin
        if (k == LAST) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (!ctrl_busy) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // controller and ROM strobes from registered state
  always_comb begin
    ctrl_cmd_valid = 1'b0;
    ctrl_cmd       = 3'd0;
    ctrl_datain    = 8'd0;
    img_rd         = 1'b0;
    img_addr       = '0;
    if (reset) begin
      unique case (1'b1)
        (state == ST_ISSUE): begin
          ctrl_cmd_valid = 1'b1;
          ctrl_cmd       = cmd_q;
          img_rd         = (cmd_q == CMD_LOAD);
        end
        (state == ST_LOAD): begin
          ctrl_datain = img_data;
          if (k != LAST) begin
            img_rd   = 1'b1;
            img_addr = k + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // datapath: head latch, pixel index, output count
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd_q      <= CMD_LOAD;
      loaded     <= 1'b0;
      k          <= '0;
      cnt        <= 8'd0;
      done_cnt_q <= 8'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= drop;
      if (pop) cmd_q <= head;
      unique case (state)
        ST_ISSUE: begin
          cnt <= 8'd0;
          k   <= '0;
          if (cmd_q == CMD_LOAD) loaded <= 1'b1;
        end
        ST_LOAD: begin
          k <= k + ADDR_W'(1);
        end
        ST_WAIT: begin
          cnt <= sat_inc(cnt, ctrl_output_valid);
          if (!ctrl_busy) begin
            done_q     <= 1'b1;
            done_cnt_q <= sat_inc(cnt, ctrl_output_valid);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
